// File: rtl/arbitro_rr_8_32.sv
// Round-robin burst arbiter feeding the 8->32 serial-to-parallel converter.
// Each grant lasts exactly BURST_LEN bytes, so every assembled word comes from one lane.
module arbitro_rr_8_32 #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int BURST_LEN = 4,
  localparam int LW        = $clog2(NUM_REQ),
  localparam int CW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                        clk_4f,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   data_req,
  output logic [NUM_REQ-1:0]          pop,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        valid_out,
  output logic [DATA_W-1:0]           data_out,
  output logic [LW-1:0]               lane_out,
  output logic                        word_start,
  output logic                        busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [LW-1:0]             rr_last_q, rr_last_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic                      valid_q, valid_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [LW-1:0]             lane_q, lane_d;
  logic                      ws_q, ws_d;

  logic [NUM_REQ-1:0][DATA_W-1:0] lane_data;
  logic [LW-1:0]                  pick;
  logic [NUM_REQ-1:0]             pick_oh;
  logic                           cnt_last;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = data_req[g*DATA_W +: DATA_W];
  end

  // Scan from the farthest offset down so the nearest requester after rr_last wins;
  // offset NUM_REQ wraps to rr_last itself, which is therefore searched last.
  always_comb begin
    logic [LW-1:0] idx;
    pick = rr_last_q;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = rr_last_q + LW'(off);
      if (req[idx]) pick = idx;
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  assign cnt_last = (cnt_q == CW'(BURST_LEN - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    data_d    = data_q;
    lane_d    = lane_q;
    ws_d      = ws_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        ws_d    = 1'b0;
        grant_d = '0;
        if (|req) begin
          grant_d   = pick_oh;
          rr_last_d = pick;
          cnt_d     = '0;
          state_d   = BURST;
        end
      end
      BURST: begin
        // rr_last_q always holds the current owner while bursting
        data_d  = lane_data[rr_last_q];
        lane_d  = rr_last_q;
        valid_d = 1'b1;
        ws_d    = (cnt_q == '0);
        if (!cnt_last) begin
          cnt_d = cnt_q + CW'(1);
        end else if (|req) begin
          grant_d   = pick_oh;
          rr_last_d = pick;
          cnt_d     = '0;
        end else begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_last_q <= LW'(NUM_REQ - 1);
      grant_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      lane_q    <= '0;
      ws_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      lane_q    <= lane_d;
      ws_q      <= ws_d;
    end
  end

  assign pop        = (state_q == BURST) ? grant_q : '0;
  assign grant      = grant_q;
  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign lane_out   = lane_q;
  assign word_start = ws_q;
  assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_arbitro_rr_8_32.sv
// Directed bench for arbitro_rr_8_32: byte sources modelled as small arrays with
// head pointers that advance on pop; outputs sampled on the falling edge.
module tb_arbitro_rr_8_32;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_req;
  logic [3:0]  pop, grant;
  logic        valid_out, word_start, busy;
  logic [7:0]  data_out;
  logic [1:0]  lane_out;

  logic [7:0]  mem [4][8];
  logic [2:0]  ptr [4];

  int checks   = 0;
  int failures = 0;

  arbitro_rr_8_32 dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .req        (req),
    .data_req   (data_req),
    .pop        (pop),
    .grant      (grant),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .lane_out   (lane_out),
    .word_start (word_start),
    .busy       (busy)
  );

  always #5 clk_4f = ~clk_4f;

  always_comb begin
    data_req = '0;
    for (int i = 0; i < 4; i++) data_req[i*8 +: 8] = mem[i][ptr[i]];
  end

  always @(posedge clk_4f or posedge reset) begin
    for (int i = 0; i < 4; i++) begin
      if (reset)       ptr[i] <= '0;
      else if (pop[i]) ptr[i] <= ptr[i] + 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_4f);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    nclk(2);
    reset = 1'b0;
  endtask

  initial begin
    int          b, lane;
    logic [1:0]  ord [4];
    reset = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) mem[i][k] = 8'((i << 4) | k);

    // reset held with all requests active
    nclk(2);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_pop",   32'(pop),   32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_data",  32'(data_out),  32'h00);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_ws",    32'(word_start), 32'h0);
    req   = 4'b0000;
    reset = 1'b0;
    nclk(1);

    // single lane 0: bytes 55 CC AA B8
    mem[0][0] = 8'h55; mem[0][1] = 8'hCC; mem[0][2] = 8'hAA; mem[0][3] = 8'hB8;
    req = 4'b0001;
    nclk(1);
    chk("sl_grant", 32'(grant), 32'h1);
    chk("sl_pop0",  32'(pop),   32'h1);
    chk("sl_busy",  32'(busy),  32'h1);
    chk("sl_vld0",  32'(valid_out), 32'h0);
    req = 4'b0000;
    begin
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h55; exp_b[1] = 8'hCC; exp_b[2] = 8'hAA; exp_b[3] = 8'hB8;
      for (int j = 0; j < 4; j++) begin
        nclk(1);
        chk("sl_data", 32'(data_out),   32'(exp_b[j]));
        chk("sl_vld",  32'(valid_out),  32'h1);
        chk("sl_ws",   32'(word_start), (j == 0) ? 32'h1 : 32'h0);
        chk("sl_lane", 32'(lane_out),   32'h0);
        chk("sl_pop",  32'(pop),        (j < 3) ? 32'h1 : 32'h0);
      end
    end
    chk("sl_ptr", 32'(ptr[0]), 32'h4);
    nclk(1);
    chk("sl_vld_end",  32'(valid_out), 32'h0);
    chk("sl_busy_end", 32'(busy), 32'h0);
    chk("sl_data_hold", 32'(data_out), 32'hB8);
    mem[0][0] = 8'h00; mem[0][1] = 8'h01; mem[0][2] = 8'h02; mem[0][3] = 8'h03;

    // round robin, all requesting: lanes 0,1,2,3,0 back to back
    do_reset();
    req = 4'b1111;
    nclk(1);
    chk("rr_grant0", 32'(grant), 32'h1);
    for (int n = 0; n < 20; n++) begin
      nclk(1);
      lane = (n / 4) % 4;
      b    = (n % 4) + 4 * (n / 16);
      chk("rr_lane", 32'(lane_out),   32'(lane));
      chk("rr_data", 32'(data_out),   32'((lane << 4) | b));
      chk("rr_vld",  32'(valid_out),  32'h1);
      chk("rr_ws",   32'(word_start), (n % 4 == 0) ? 32'h1 : 32'h0);
      if (n == 18) req = 4'b0000;
    end
    nclk(1);
    chk("rr_vld_end", 32'(valid_out), 32'h0);

    // lane 2 drops req after first pop; burst still completes, then lane 0
    do_reset();
    req = 4'b0100;
    nclk(1);
    chk("md_grant2", 32'(grant), 32'h4);
    nclk(1);
    req = 4'b0001;
    nclk(3);
    chk("md_ptr2",   32'(ptr[2]), 32'h4);
    chk("md_grant0", 32'(grant),  32'h1);
    nclk(1);
    chk("md_lane0",  32'(lane_out),   32'h0);
    chk("md_ws",     32'(word_start), 32'h1);
    req = 4'b0000;

    // two requesters alternate: 0,3,0,3
    do_reset();
    ord[0] = 2'd0; ord[1] = 2'd3; ord[2] = 2'd0; ord[3] = 2'd3;
    req = 4'b1001;
    nclk(1);
    for (int bb = 0; bb < 4; bb++) begin
      nclk(1);
      chk("fa_lane", 32'(lane_out),   32'(ord[bb]));
      chk("fa_ws",   32'(word_start), 32'h1);
      nclk(3);
    end
    req = 4'b0000;
    nclk(2);

    // async reset during lane 1's third byte, then resume
    do_reset();
    req = 4'b0010;
    nclk(1);
    nclk(3);
    chk("ar_data3", 32'(data_out), 32'h12);
    #1 reset = 1'b1;
    #1;
    chk("ar_grant", 32'(grant),     32'h0);
    chk("ar_pop",   32'(pop),       32'h0);
    chk("ar_vld",   32'(valid_out), 32'h0);
    chk("ar_data",  32'(data_out),  32'h0);
    chk("ar_busy",  32'(busy),      32'h0);
    nclk(2);
    reset = 1'b0;
    req   = 4'b0010;
    nclk(2);
    chk("ar_res_ws",   32'(word_start), 32'h1);
    chk("ar_res_data", 32'(data_out),   32'h10);
    chk("ar_res_lane", 32'(lane_out),   32'h1);
    req = 4'b0000;
    nclk(4);
    do_reset();
    req = 4'b0011;
    nclk(1);
    chk("ar_prio", 32'(grant), 32'h1);
    req = 4'b0000;
    nclk(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_8_32.md
Name: arbitro_rr_8_32

Overview:
- Round-robin burst arbiter that shares the 8-bit byte input of the 8→32 serial-to-parallel converter among NUM_REQ byte sources.
- A granted source keeps the grant for exactly BURST_LEN consecutive bytes, so every 32-bit word the converter assembles comes from a single lane.
- Runs in the clk_4f domain and drives the converter's valid/data_in directly, plus a lane tag and a word-start marker.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- DATA_W, 8, byte width.
- BURST_LEN, 4, bytes per grant (one 32-bit word).

Ports:
- clk_4f  input  1  byte-rate clock; all logic on its rising edge.
- reset  input  1  asynchronous reset, active-high.
- req  input  NUM_REQ  req[i]=1 means source i holds at least BURST_LEN bytes ready.
- data_req  input  NUM_REQ*DATA_W  current head byte of each source; lane i is bits [i*DATA_W +: DATA_W].
- pop  output  NUM_REQ  one-hot, combinational; source i advances its head at the edge where pop[i]=1.
- grant  output  NUM_REQ  registered one-hot owner; all zero when idle.
- valid_out  output  1  registered; drives the converter's valid.
- data_out  output  DATA_W  registered; drives the converter's data_in.
- lane_out  output  log2(NUM_REQ)  registered index of the lane that supplied data_out.
- word_start  output  1  registered; 1 with the first byte of each burst.
- busy  output  1  1 while state is BURST.

Behaviour:
- State machine: IDLE and BURST. Internal registers: byte counter cnt (0..BURST_LEN-1) and rr_last (index of the last granted lane).
- Reset (asynchronous, active-high): state=IDLE, cnt=0, rr_last=NUM_REQ-1, and all outputs zero (grant, valid_out, data_out, lane_out, word_start, busy). pop is then 0 by construction. Reset asserted mid-burst aborts the burst immediately; the partial word is discarded and no further pop is issued.
- Round-robin pick: the first i with req[i]=1, searching rr_last+1, rr_last+2, … modulo NUM_REQ. The current owner's own index is searched last.
- IDLE:
  - If any req is set at an edge: grant=one-hot(pick), rr_last=pick, cnt=0, state=BURST.
  - Otherwise remain in IDLE with grant=0.
- pop = grant when state=BURST, else 0. This is combinational from registered state only and never depends on req.
- BURST, at each edge:
  - data_out=data_req[owner], lane_out=owner, valid_out=1, word_start=(cnt==0).
  - If cnt<BURST_LEN-1: cnt increments.
  - If cnt==BURST_LEN-1 (last byte) and any req is set: pick using the updated priority (owner last), load the new grant, rr_last=pick, cnt=0, stay in BURST. There is no idle gap between bursts.
  - If cnt==BURST_LEN-1 and no req is set: state=IDLE, grant=0.
- IDLE output update: at an edge in IDLE, valid_out=0 and word_start=0. data_out and lane_out hold their last values.
- Latency:
  - req sampled at edge k → grant and pop high after edge k.
  - First byte on data_out/valid_out after edge k+1.
  - Last byte after edge k+BURST_LEN; valid_out falls after edge k+BURST_LEN+1 if no further grant.
- req is sampled only at arbitration points (IDLE, or the last byte of a burst). Deassertion mid-burst is ignored and the burst always completes BURST_LEN pops.
- A requester whose req is held continuously is granted at least once in every NUM_REQ bursts.
- Throughput: one byte per clk_4f while busy, which equals one 32-bit word per clk_f.

Test Plan:
- Reset: hold reset=1 with req=4'b1111 → grant=0, pop=0, valid_out=0, data_out=8'h00. Assert reset asynchronously mid-burst → all outputs 0 immediately, without waiting for a clock edge.
- Single lane: req=4'b0001, lane 0 bytes 55,CC,AA,B8 → pop[0] high for 4 cycles; data_out 55,CC,AA,B8 on consecutive edges; word_start only with 55; lane_out=0; then valid_out=0 and busy=0.
- Round robin: req=4'b1111 held, lane i bytes = {i,i,i,i} → grant order 0,1,2,3,0; bursts back-to-back with valid_out continuously 1 for 20 cycles; word_start every 4th byte.
- Mid-burst drop: lane 2 granted, req[2] drops after the 1st pop → 4 pops still issued; grant then moves to the next requester or to IDLE.
- Back-to-back fairness: req=4'b1001 held, starting after reset → grants 0,3,0,3; no lane granted twice in a row while the other requests.
- Reset mid-operation then resume: reset pulse during lane 1's 3rd byte, then req=4'b0010 → new burst starts with word_start=1 and cnt=0, and lane 0 has priority over lane 1 if both request.
